// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter that serialises SPI register commands from several
// requesters onto one command handler, with busy tracking and a timeout.
module spi_cmd_arbiter #(
    parameter int PACKAGE_SIZE = 8,
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                                clk,
    input  logic                                rstb,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*PACKAGE_SIZE-1:0]     req_cmd,
    input  logic [NUM_REQ*PACKAGE_SIZE-1:0]     req_data,
    input  logic [NUM_REQ*(PACKAGE_SIZE-1)-1:0] req_addr,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [PACKAGE_SIZE-1:0]             rsp_data,
    output logic                                rsp_err,
    output logic [PACKAGE_SIZE-1:0]             hnd_cmd,
    output logic [PACKAGE_SIZE-1:0]             hnd_data,
    output logic [PACKAGE_SIZE-2:0]             hnd_addr,
    output logic                                hnd_exec,
    input  logic                                hnd_busy,
    input  logic [PACKAGE_SIZE-1:0]             hnd_data_out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] IDX_LAST = PW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        RESP       = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             ptr_q, ptr_d;
    logic [PW-1:0]             grant_q, grant_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [NUM_REQ-1:0]        req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [PACKAGE_SIZE-1:0]   rsp_data_q, rsp_data_d;
    logic                      rsp_err_q, rsp_err_d;
    logic [PACKAGE_SIZE-1:0]   hnd_cmd_q, hnd_cmd_d;
    logic [PACKAGE_SIZE-1:0]   hnd_data_q, hnd_data_d;
    logic [PACKAGE_SIZE-2:0]   hnd_addr_q, hnd_addr_d;
    logic                      hnd_exec_q, hnd_exec_d;

    logic                      sel_found;
    logic [PW-1:0]             sel_idx;
    int                        cand;

    // First requesting index at or above ptr, wrapping past NUM_REQ-1.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = PW'(cand);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        hnd_cmd_d   = hnd_cmd_q;
        hnd_data_d  = hnd_data_q;
        hnd_addr_d  = hnd_addr_q;
        hnd_exec_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!hnd_busy && sel_found) begin
                    grant_d              = sel_idx;
                    req_ready_d[sel_idx] = 1'b1;
                    hnd_cmd_d            = req_cmd[sel_idx*PACKAGE_SIZE +: PACKAGE_SIZE];
                    hnd_data_d           = req_data[sel_idx*PACKAGE_SIZE +: PACKAGE_SIZE];
                    hnd_addr_d           = req_addr[sel_idx*(PACKAGE_SIZE-1) +: (PACKAGE_SIZE-1)];
                    state_d              = ISSUE;
                end
            end
            ISSUE: begin
                hnd_exec_d = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_START;
            end
            WAIT_START: begin
                cnt_d = cnt_q + CW'(1);
                if (hnd_busy) begin
                    if (cnt_q == CNT_LAST) begin
                        rsp_data_d           = '0;
                        rsp_err_d            = 1'b1;
                        rsp_valid_d[grant_q] = 1'b1;
                        state_d              = RESP;
                    end else begin
                        state_d = WAIT_DONE;
                    end
                end else if (cnt_q == CW'(1)) begin
                    // Handler never went busy: treat as an instant completion.
                    rsp_data_d           = hnd_data_out;
                    rsp_err_d            = 1'b0;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = RESP;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + CW'(1);
                if (!hnd_busy) begin
                    rsp_data_d           = hnd_data_out;
                    rsp_err_d            = 1'b0;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d           = '0;
                    rsp_err_d            = 1'b1;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = RESP;
                end
            end
            RESP: begin
                ptr_d   = (grant_q == IDX_LAST) ? '0 : grant_q + PW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            hnd_cmd_q   <= '0;
            hnd_data_q  <= '0;
            hnd_addr_q  <= '0;
            hnd_exec_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            hnd_cmd_q   <= hnd_cmd_d;
            hnd_data_q  <= hnd_data_d;
            hnd_addr_q  <= hnd_addr_d;
            hnd_exec_q  <= hnd_exec_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign hnd_cmd   = hnd_cmd_q;
    assign hnd_data  = hnd_data_q;
    assign hnd_addr  = hnd_addr_q;
    assign hnd_exec  = hnd_exec_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter: single command, round-robin contention,
// pointer wrap, timeout, reset mid-command and a handler that never goes busy.
module tb_spi_cmd_arbiter;

    localparam int PS = 8;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*PS-1:0]  req_cmd = '0;
    logic [NR*PS-1:0]  req_data = '0;
    logic [NR*(PS-1)-1:0] req_addr = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [PS-1:0]     rsp_data;
    logic              rsp_err;
    logic [PS-1:0]     hnd_cmd;
    logic [PS-1:0]     hnd_data;
    logic [PS-2:0]     hnd_addr;
    logic              hnd_exec;
    logic              hnd_busy = 1'b0;
    logic [PS-1:0]     hnd_data_out = '0;

    int checks = 0;
    int errors = 0;

    spi_cmd_arbiter #(.PACKAGE_SIZE(PS), .NUM_REQ(NR), .TIMEOUT(16)) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_data(req_data), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .hnd_cmd(hnd_cmd), .hnd_data(hnd_data), .hnd_addr(hnd_addr), .hnd_exec(hnd_exec),
        .hnd_busy(hnd_busy), .hnd_data_out(hnd_data_out)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [7:0] cmd, input logic [6:0] addr,
                           input logic [7:0] data);
        req_cmd[i*PS +: PS]          = cmd;
        req_addr[i*(PS-1) +: (PS-1)] = addr;
        req_data[i*PS +: PS]         = data;
    endtask

    // Returns the number of negedges until req_ready is seen, 0 if never.
    task automatic wait_ready(input int limit, output int n);
        n = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int limit, output int n);
        n = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, hnd_cmd, hnd_data, hnd_addr, hnd_exec} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b rsp=%b data=%h err=%b cmd=%h wdata=%h addr=%h exec=%b, required all 0",
                     req_ready, rsp_valid, rsp_data, rsp_err, hnd_cmd, hnd_data, hnd_addr, hnd_exec);
        end
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_single();
        int n;
        set_req(0, 8'h02, 7'h15, 8'hA5);
        req_valid = 4'b0001;
        wait_ready(1, n);
        checks++;
        if (req_ready !== 4'b0001 || n != 1) begin
            errors++;
            $display("FAIL single_ready: got %b after %0d, required 0001 after 1", req_ready, n);
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (hnd_exec !== 1'b1 || hnd_cmd !== 8'h02 || hnd_addr !== 7'h15 || hnd_data !== 8'hA5 || req_ready !== '0) begin
            errors++;
            $display("FAIL single_exec: got exec=%b cmd=%h addr=%h data=%h ready=%b, required 1/02/15/A5/0000",
                     hnd_exec, hnd_cmd, hnd_addr, hnd_data, req_ready);
        end
        hnd_busy = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (hnd_exec !== 1'b0 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL single_busy: got exec=%b rsp=%b, required 0/0000", hnd_exec, rsp_valid);
        end
        hnd_busy     = 1'b0;
        hnd_data_out = 8'h3C;
        wait_rsp(4, n);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 8'h3C || rsp_err !== 1'b0 || n != 1 || hnd_cmd !== 8'h02) begin
            errors++;
            $display("FAIL single_rsp: got rsp=%b data=%h err=%b after %0d cmd=%h, required 0001/3C/0 after 1 cmd=02",
                     rsp_valid, rsp_data, rsp_err, n, hnd_cmd);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== '0) begin
            errors++;
            $display("FAIL single_rsp_pulse: got %b, required 0000", rsp_valid);
        end
    endtask

    task automatic test_contention();
        int ord[5] = '{0, 1, 2, 3, 0};
        int n;
        logic [3:0] exp_oh;
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 8'h10 + 8'(i), 7'h20 + 7'(i), 8'h30 + 8'(i));
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_oh = 4'b0001 << ord[g];
            wait_ready(8, n);
            checks++;
            if (req_ready !== exp_oh) begin
                errors++;
                $display("FAIL contention_grant%0d: got %b, required %b", g, req_ready, exp_oh);
            end
            @(negedge clk);
            checks++;
            if (hnd_exec !== 1'b1 || hnd_cmd !== 8'h10 + 8'(ord[g])) begin
                errors++;
                $display("FAIL contention_exec%0d: got exec=%b cmd=%h, required 1/%h", g, hnd_exec, hnd_cmd, 8'h10 + 8'(ord[g]));
            end
            @(negedge clk);
            checks++;
            if (hnd_exec !== 1'b0) begin
                errors++;
                $display("FAIL contention_exec_pulse%0d: got %b, required 0", g, hnd_exec);
            end
            @(negedge clk);
            checks++;
            if (rsp_valid !== exp_oh) begin
                errors++;
                $display("FAIL contention_rsp%0d: got %b, required %b", g, rsp_valid, exp_oh);
            end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int n;
        req_valid = 4'b0100;
        wait_ready(4, n);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_setup: got %b, required 0100", req_ready);
        end
        req_valid = '0;
        wait_rsp(6, n);
        req_valid = 4'b0101;
        wait_ready(6, n);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_first: got %b, required 0001", req_ready);
        end
        req_valid = 4'b0100;
        wait_rsp(6, n);
        wait_ready(6, n);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_second: got %b, required 0100", req_ready);
        end
        req_valid = '0;
        wait_rsp(6, n);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        hnd_data_out = 8'hFF;
        req_valid = 4'b0010;
        wait_ready(4, n);
        req_valid = '0;
        @(negedge clk);
        hnd_busy = 1'b1;
        wait_rsp(40, n);
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_data !== 8'h00 || n != 16) begin
            errors++;
            $display("FAIL timeout_rsp: got rsp=%b err=%b data=%h after %0d, required 0010/1/00 after 16",
                     rsp_valid, rsp_err, rsp_data, n);
        end
        hnd_busy = 1'b0;
        req_valid = 4'b1000;
        wait_ready(6, n);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_next_ready: got %b, required 1000", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        hnd_busy = 1'b1;
        repeat (2) @(negedge clk);
        hnd_busy     = 1'b0;
        hnd_data_out = 8'h5A;
        wait_rsp(4, n);
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_err !== 1'b0 || rsp_data !== 8'h5A) begin
            errors++;
            $display("FAIL timeout_next_rsp: got rsp=%b err=%b data=%h, required 1000/0/5A", rsp_valid, rsp_err, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        req_valid = 4'b0010;
        wait_ready(4, n);
        req_valid = '0;
        wait_rsp(6, n);
        set_req(2, 8'hC3, 7'h6A, 8'h99);
        req_valid = 4'b0100;
        wait_ready(6, n);
        req_valid = '0;
        @(negedge clk);
        hnd_busy = 1'b1;
        repeat (3) @(negedge clk);
        #2 rstb = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, hnd_cmd, hnd_data, hnd_addr, hnd_exec} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got ready=%b rsp=%b data=%h err=%b cmd=%h wdata=%h addr=%h exec=%b, required all 0",
                     req_ready, rsp_valid, rsp_data, rsp_err, hnd_cmd, hnd_data, hnd_addr, hnd_exec);
        end
        hnd_busy = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid != '0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: got %0d responses, required 0", seen);
        end
        req_valid = 4'b1111;
        wait_ready(4, n);
        checks++;
        if (req_ready !== 4'b0001 || n != 1) begin
            errors++;
            $display("FAIL reset_mid_first_grant: got %b after %0d, required 0001 after 1", req_ready, n);
        end
        req_valid = '0;
        wait_rsp(6, n);
        checks++;
        if (rsp_valid !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid_rsp: got %b, required 0001", rsp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_no_busy();
        int n;
        hnd_busy  = 1'b1;
        req_valid = 4'b1000;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL idle_busy_hold: got %b, required 0000", req_ready);
        end
        hnd_busy = 1'b0;
        wait_ready(4, n);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL idle_busy_release: got %b, required 1000", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        wait_rsp(6, n);
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_err !== 1'b0 || n != 2) begin
            errors++;
            $display("FAIL no_busy_rsp: got rsp=%b err=%b after %0d, required 1000/0 after 2", rsp_valid, rsp_err, n);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_no_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_cmd_arbiter.md
SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

Interface
REQ-001 SHALL have parameter PACKAGE_SIZE, default 8, SPI package width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters, range 2..8.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum handler-busy cycles per command.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rstb  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester command request, held until req_ready.
REQ-007 SHALL have port req_cmd  input  NUM_REQ*PACKAGE_SIZE  packed command; requester i uses slice i.
REQ-008 SHALL have port req_data  input  NUM_REQ*PACKAGE_SIZE  packed write data.
REQ-009 SHALL have port req_addr  input  NUM_REQ*(PACKAGE_SIZE-1)  packed register address.
REQ-010 SHALL have port req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-011 SHALL have port rsp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-012 SHALL have port rsp_data  output  PACKAGE_SIZE  handler read data, valid with rsp_valid.
REQ-013 SHALL have port rsp_err  output  1  timeout flag, valid with rsp_valid.
REQ-014 SHALL have ports hnd_cmd, hnd_data  output  PACKAGE_SIZE each, and hnd_addr  output  PACKAGE_SIZE-1: command-handler inputs.
REQ-015 SHALL have port hnd_exec  output  1  one-cycle execute strobe to the command handler.
REQ-016 SHALL have port hnd_busy  input  1  command-handler busy.
REQ-017 SHALL have port hnd_data_out  input  PACKAGE_SIZE  command-handler read data.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP.
REQ-019 SHALL register all outputs; none SHALL combinationally depend on inputs.
REQ-020 IDLE: if any req_valid is set, SHALL grant the first set bit found searching upward from pointer ptr, wrapping from NUM_REQ-1 to 0.
REQ-021 On a grant, SHALL in the same clock edge latch that requester's cmd/data/addr into hnd_cmd/hnd_data/hnd_addr, pulse its req_ready bit, store the grant index and enter ISSUE.
REQ-022 IDLE: if hnd_busy=1, SHALL NOT grant; it SHALL wait until hnd_busy=0.
REQ-023 ISSUE: SHALL drive hnd_exec=1 for exactly one cycle, then enter WAIT_START.
REQ-024 WAIT_START: on hnd_busy=1, SHALL enter WAIT_DONE.
REQ-025 WAIT_START: if hnd_busy stays 0 for 2 cycles, SHALL treat the command as complete and enter RESP.
REQ-026 WAIT_DONE: on hnd_busy=0, SHALL capture hnd_data_out into rsp_data, clear the error flag and enter RESP.
REQ-027 A cycle counter SHALL be cleared on entry to WAIT_START and incremented in WAIT_START/WAIT_DONE.
REQ-028 When the counter reaches TIMEOUT-1 with hnd_busy still 1, SHALL set the error flag, load rsp_data=0 and enter RESP.
REQ-029 RESP: SHALL pulse rsp_valid at the granted index with rsp_err = error flag.
REQ-030 RESP: SHALL set ptr = (grant+1) mod NUM_REQ and return to IDLE.
REQ-031 SHALL keep hnd_cmd/hnd_data/hnd_addr stable from ISSUE through RESP.
REQ-032 SHALL keep at most one command outstanding; req_valid changes outside IDLE SHALL have no effect.
REQ-033 Simultaneous requests SHALL be served in round-robin order; no requester SHALL wait more than NUM_REQ-1 grants.
REQ-034 A requester deasserting req_valid before its req_ready pulse SHALL be dropped without a response.
REQ-035 Minimum latency SHALL be: req_ready at cycle 1 after req_valid, hnd_exec at cycle 2, rsp_valid 1 cycle after hnd_busy falls.

Reset
REQ-036 On rstb=0, SHALL asynchronously clear state to IDLE, ptr to 0, the counter, the grant index and the error flag.
REQ-037 On rstb=0, SHALL drive all outputs to 0.
REQ-038 Reset mid-command SHALL abort with no rsp_valid; the first grant after reset SHALL start from requester 0.

Verification
REQ-039 Single request: req_valid=0001, cmd=0x02, addr=0x15, data=0xA5; handler busy 5 cycles returning 0x3C -> req_ready=0001, one hnd_exec with 0x02/0x15/0xA5, rsp_valid=0001, rsp_data=0x3C, rsp_err=0.
REQ-040 Contention: req_valid=1111 held continuously -> grant order 0,1,2,3,0 with one hnd_exec per grant.
REQ-041 Wrap: ptr=3 and req_valid=0101 -> requester 0 is granted first, then requester 2.
REQ-042 Timeout: TIMEOUT=16, hnd_busy stuck at 1 -> rsp_valid after 16 busy cycles with rsp_err=1, rsp_data=0x00; the next request is then served normally.
REQ-043 Reset during WAIT_DONE -> all outputs 0 immediately, no rsp_valid; a new request after reset is granted to requester 0 first.
REQ-044 Handler never asserts busy -> rsp_valid 2 cycles after WAIT_START entry, rsp_err=0.
